// File: rtl/qspi_xip_pkg.sv
// Shared definitions for the XIP flash read path.
// Contents:
//   - default values for the flash address width, the line width and the
//     WAIT-state abort limit
//   - width of the WAIT cycle counter
//   - the arbiter state encoding
//   - the round-robin winner selection helper
package qspi_xip_pkg;

  localparam int unsigned AW_DEF        = 24;
  localparam int unsigned LINE_SIZE_DEF = 128;
  localparam int unsigned TIMEOUT_DEF   = 255;

  // TIMEOUT is limited to 1..255, so eight bits always hold the WAIT count.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Round-robin pick.
  // A lone pending port always wins.
  // On a tie, the port that did not own the previous transaction wins.
  function automatic logic rr_pick(input logic pend0, input logic pend1, input logic last);
    logic win;
    if (pend0 && pend1) begin
      win = ~last;
    end else if (pend1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/flash_rd_req_slot.sv
// One request port's pending flag and line-aligned address slot.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   req_i    : request pulse; sets the flag and (re)loads the address
//   addr_i   : byte address; bits [3:0] are dropped when stored
//   clr_i    : clears the flag; a simultaneous req_i takes priority
//   pend_o   : request pending
//   addr_o   : stored line address
module flash_rd_req_slot
  import qspi_xip_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [AW-1:0] addr_i,
  input  logic          clr_i,
  output logic          pend_o,
  output logic [AW-1:0] addr_o
);

  localparam logic [AW-1:0] LINE_MASK = {{(AW-4){1'b1}}, 4'h0};

  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;

  // Next-state logic for the flag and the slot.
  // A new request re-arms the flag even in the cycle it is being cleared,
  // so a re-request made in the port's own issue cycle is not lost.
  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    if (req_i) begin
      pend_d = 1'b1;
      addr_d = addr_i & LINE_MASK;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Slot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      addr_q <= '0;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
    end
  end

  assign pend_o = pend_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/flash_rd_arbiter.sv
// Two-port round-robin arbiter in front of a single flash line reader.
// Port 0 serves instruction fetches and port 1 serves data reads.
// Ports:
//   clk, rst             : clock and asynchronous active-high reset
//   req0/addr0           : port-0 request pulse and byte address
//   done0/err0           : port-0 line-delivered and timeout pulses
//   req1/addr1           : port-1 request pulse and byte address
//   done1/err1           : port-1 line-delivered and timeout pulses
//   line                 : last delivered line, held until the next capture
//   fr_rd/fr_addr        : start pulse and line address to the flash reader
//   fr_done/fr_line      : completion pulse and line data from the flash reader
//   busy                 : transaction in progress
//   owner                : port of the current or last transaction
// All outputs are registered.
module flash_rd_arbiter
  import qspi_xip_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned LINE_SIZE = LINE_SIZE_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [AW-1:0]        addr0,
  output logic                 done0,
  output logic                 err0,
  input  logic                 req1,
  input  logic [AW-1:0]        addr1,
  output logic                 done1,
  output logic                 err1,
  output logic [LINE_SIZE-1:0] line,
  output logic                 fr_rd,
  output logic [AW-1:0]        fr_addr,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line,
  output logic                 busy,
  output logic                 owner
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LINE_SIZE-1:0] line_q, line_d;
  logic                 fr_rd_q, fr_rd_d;
  logic [AW-1:0]        fr_addr_q, fr_addr_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic                 err0_q, err0_d;
  logic                 err1_q, err1_d;
  logic                 busy_q, busy_d;

  logic          pend0_s, pend1_s;
  logic [AW-1:0] slot_addr0_s, slot_addr1_s;
  logic          clr0_s, clr1_s;
  logic          win_s;

  // The winner's flag is released in its ISSUE cycle.
  // owner_q doubles as the last-owner reference for round-robin.
  assign clr0_s = (state_q == ST_ISSUE) && (owner_q == 1'b0);
  assign clr1_s = (state_q == ST_ISSUE) && (owner_q == 1'b1);

  flash_rd_req_slot #(.AW(AW)) u_slot0 (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req0),
    .addr_i (addr0),
    .clr_i  (clr0_s),
    .pend_o (pend0_s),
    .addr_o (slot_addr0_s)
  );

  flash_rd_req_slot #(.AW(AW)) u_slot1 (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req1),
    .addr_i (addr1),
    .clr_i  (clr1_s),
    .pend_o (pend1_s),
    .addr_o (slot_addr1_s)
  );

  // Next-state and registered-output logic of the transaction FSM.
  // Every pulse output is loaded for the cycle in which its state is entered.
  // The abort decision is taken in the WAIT cycle whose count equals TIMEOUT.
  // err is therefore seen in the following cycle, when the FSM is already in IDLE.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    fr_addr_d = fr_addr_q;
    fr_rd_d   = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    win_s     = rr_pick(pend0_s, pend1_s, owner_q);
    case (state_q)
      ST_IDLE: begin
        if (pend0_s || pend1_s) begin
          owner_d   = win_s;
          fr_addr_d = win_s ? slot_addr1_s : slot_addr0_s;
          fr_rd_d   = 1'b1;
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the abort cycle still delivers the line.
        if (fr_done) begin
          line_d  = fr_line;
          done0_d = (owner_q == 1'b0);
          done1_d = (owner_q == 1'b1);
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_C) begin
          err0_d  = (owner_q == 1'b0);
          err1_d  = (owner_q == 1'b1);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and output registers.
  // Owner resets to 1, so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b1;
      cnt_q     <= '0;
      line_q    <= '0;
      fr_rd_q   <= 1'b0;
      fr_addr_q <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      fr_rd_q   <= fr_rd_d;
      fr_addr_q <= fr_addr_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      busy_q    <= busy_d;
    end
  end

  assign done0   = done0_q;
  assign done1   = done1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign line    = line_q;
  assign fr_rd   = fr_rd_q;
  assign fr_addr = fr_addr_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// Self-checking bench for flash_rd_arbiter, built with TIMEOUT = 10.
// Every cycle, all outputs are compared against a reference model.
// The model follows the transaction timeline by cycle number:
//   - a decision in cycle c puts ISSUE in cycle c+1
//   - WAIT count k falls in cycle issue+1+k
//   - a completion in cycle c pulses done in cycle c+1
module tb_flash_rd_arbiter;

  localparam int TMO = 10;
  localparam logic [127:0] LINE_A5 = {16{8'hA5}};

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, fr_done;
  logic [23:0]  addr0, addr1;
  logic         done0, done1, err0, err1, fr_rd, busy, owner;
  logic [127:0] line, fr_line;
  logic [23:0]  fr_addr;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_pend [2];
  logic [23:0] m_paddr [2];
  logic        m_own;
  bit          m_active;
  int          m_issue_at, m_idle_ok, cyc;
  logic [127:0] m_line;
  logic        e_fr_rd, e_done0, e_done1, e_err0, e_err1, e_busy;
  logic [23:0] e_fr_addr;

  flash_rd_arbiter #(.AW(24), .LINE_SIZE(128), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .done0(done0), .err0(err0),
    .req1(req1), .addr1(addr1), .done1(done1), .err1(err1),
    .line(line), .fr_rd(fr_rd), .fr_addr(fr_addr),
    .fr_done(fr_done), .fr_line(fr_line),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend[0] = 1'b0;  m_pend[1] = 1'b0;
    m_paddr[0] = 24'h0; m_paddr[1] = 24'h0;
    m_own = 1'b1; m_active = 1'b0; m_issue_at = -1; m_idle_ok = cyc;
    m_line = 128'h0;
    e_fr_rd = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
    e_busy = 1'b0; e_fr_addr = 24'h0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".fr_rd"}, fr_rd, e_fr_rd);
    chk({tag, ".fr_addr"}, fr_addr, e_fr_addr);
    chk({tag, ".done0"}, done0, e_done0);
    chk({tag, ".done1"}, done1, e_done1);
    chk({tag, ".err0"}, err0, e_err0);
    chk({tag, ".err1"}, err1, e_err1);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".owner"}, owner, m_own);
    chk({tag, ".line"}, line, m_line);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r0, input logic [23:0] a0, input logic r1,
                      input logic [23:0] a1, input logic fd, input logic [127:0] fl);
    int k;
    logic w;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; fr_done = fd; fr_line = fl;
    e_fr_rd = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
    if (m_active && cyc == m_issue_at) m_pend[m_own] = 1'b0;
    if (m_active && cyc > m_issue_at) begin
      k = cyc - m_issue_at - 1;
      if (fd) begin
        m_line = fl;
        if (m_own) e_done1 = 1'b1; else e_done0 = 1'b1;
        m_active = 1'b0; m_idle_ok = cyc + 2;
      end else if (k == TMO) begin
        if (m_own) e_err1 = 1'b1; else e_err0 = 1'b1;
        m_active = 1'b0; m_idle_ok = cyc + 1;
      end
    end
    if (!m_active && cyc >= m_idle_ok && (m_pend[0] || m_pend[1])) begin
      if (m_pend[0] && m_pend[1]) w = ~m_own;
      else w = m_pend[1];
      m_own = w; e_fr_rd = 1'b1; e_fr_addr = m_paddr[w];
      m_active = 1'b1; m_issue_at = cyc + 1;
    end
    if (r0) begin m_pend[0] = 1'b1; m_paddr[0] = {a0[23:4], 4'h0}; end
    if (r1) begin m_pend[1] = 1'b1; m_paddr[1] = {a1[23:4], 4'h0}; end
    e_busy = m_active || e_done0 || e_done1;
    cyc++;
    @(posedge clk);
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 128'h0);
  endtask

  task automatic respond(input int n, input logic [127:0] fl);
    idle(n);
    step(1'b0, 24'h0, 1'b0, 24'h0, 1'b1, fl);
  endtask

  task automatic wait_issue(input logic eo, input logic [23:0] ea, input string tag, output int n);
    n = 0;
    while (fr_rd !== 1'b1 && n < 20) begin
      idle(1);
      n++;
    end
    chk({tag, "_rd"}, fr_rd, 1'b1);
    chk({tag, "_own"}, owner, eo);
    chk({tag, "_addr"}, fr_addr, ea);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fr_done = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [127:0] saved;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 24'h0; addr1 = 24'h0;
    fr_done = 1'b0; fr_line = 128'h0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Single request: fr_rd two cycles after req, done one cycle after fr_done
    step(1'b1, 24'h012345, 1'b0, 24'h0, 1'b0, 128'h0);
    idle(1);
    chk("single_fr_rd", fr_rd, 1'b1);
    chk("single_fr_addr", fr_addr, 24'h012340);
    idle(7);
    step(1'b0, 24'h0, 1'b0, 24'h0, 1'b1, LINE_A5);
    chk("single_done0", done0, 1'b1);
    chk("single_done1", done1, 1'b0);
    chk("single_line", line, LINE_A5);

    // Tie after reset: port 0 first, then port 1 after one IDLE cycle
    do_reset();
    step(1'b1, 24'h000400, 1'b1, 24'h000800, 1'b0, 128'h0);
    wait_issue(1'b0, 24'h000400, "tie1_p0", n);
    step(1'b1, 24'h000440, 1'b1, 24'h000880, 1'b0, 128'h0);
    respond(2, 128'h1111);
    wait_issue(1'b1, 24'h000880, "tie1_p1", n);
    chk("tie1_gap", n, 2);
    respond(2, 128'h2222);
    wait_issue(1'b0, 24'h000440, "tie2_p0", n);
    chk("tie2_gap", n, 2);
    respond(2, 128'h3333);
    idle(2);

    // Timeout on port 1
    saved = m_line;
    step(1'b0, 24'h0, 1'b1, 24'h001234, 1'b0, 128'h0);
    wait_issue(1'b1, 24'h001230, "tmo_issue", n);
    idle(TMO + 2);
    chk("tmo_err1", err1, 1'b1);
    chk("tmo_err0", err0, 1'b0);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_line", line, saved);
    step(1'b0, 24'h0, 1'b1, 24'h002000, 1'b0, 128'h0);
    wait_issue(1'b1, 24'h002000, "tmo_again", n);
    respond(4, 128'h4444);
    chk("tmo_again_done1", done1, 1'b1);
    idle(2);

    // fr_done in the same cycle as the abort decision
    step(1'b1, 24'h003000, 1'b0, 24'h0, 1'b0, 128'h0);
    wait_issue(1'b0, 24'h003000, "coin_issue", n);
    respond(TMO + 1, 128'h5555);
    chk("coin_done0", done0, 1'b1);
    chk("coin_err0", err0, 1'b0);
    idle(2);

    // Overwrite of port-1 slot while port 0 waits
    step(1'b1, 24'h005000, 1'b0, 24'h0, 1'b0, 128'h0);
    wait_issue(1'b0, 24'h005000, "ovw_p0", n);
    step(1'b0, 24'h0, 1'b1, 24'h000100, 1'b0, 128'h0);
    idle(1);
    step(1'b0, 24'h0, 1'b1, 24'h000200, 1'b0, 128'h0);
    respond(2, 128'h6666);
    wait_issue(1'b1, 24'h000200, "ovw_p1", n);
    respond(2, 128'h7777);
    idle(2);

    // Reset during WAIT, then a stray fr_done
    step(1'b1, 24'h006000, 1'b0, 24'h0, 1'b0, 128'h0);
    wait_issue(1'b0, 24'h006000, "rstw_issue", n);
    idle(3);
    do_reset();
    step(1'b0, 24'h0, 1'b0, 24'h0, 1'b1, LINE_A5);
    chk("rstw_done0", done0, 1'b0);
    chk("rstw_done1", done1, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_line", line, 128'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) == 0, 24'($urandom),
             $urandom_range(0, 9) == 0, 24'($urandom),
             $urandom_range(0, 7) == 0,
             {$urandom, $urandom, $urandom, $urandom});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
